pixel_word_packer: RTL and testbench

Packs the thresholded 1-bit pixel stream from the Bayer/threshold stage into 32-bit words for the two SDRAM write FIFOs (low half to port 1, high half to port 2). It runs on the camera pixel clock and issues one write strobe per completed word. This removes the free-running divide-by-32 write clock. It frames the packing on FVAL and absorbs one word of FIFO back-pressure.

---
 rtl/pix_pack_pkg.sv | 20 ++
 rtl/pixel_word_packer_if.sv | 31 +++
 rtl/pix_word_hold.sv | 54 +++++
 rtl/pixel_word_packer.sv | 136 +++++++++++++
 tb/tb_pixel_word_packer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pix_pack_pkg.sv
// Shared constants and state encoding for the 1-bit pixel word packer.
// Exports word/frame geometry, counter widths and the packer FSM state enum.
package pix_pack_pkg;

    localparam int WORD_W          = 32;
    localparam int HALF_W          = WORD_W / 2;
    localparam int FRAME_PIXELS    = 307200;
    localparam int WORDS_PER_FRAME = FRAME_PIXELS / WORD_W;
    localparam int WCNT_W          = 14;
    localparam int PCNT_W          = 19;
    localparam int BCNT_W          = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/pixel_word_packer_if.sv
// Pixel-in / word-out signal bundle of the packer.
// master: camera + FIFO side (drives i*), slave: the packer (drives o*).
interface pixel_word_packer_if;
    import pix_pack_pkg::*;

    logic              iPIX;
    logic              iDVAL;
    logic              iFVAL;
    logic              iENABLE;
    logic              iFULL;
    logic [HALF_W-1:0] oDATA_LO;
    logic [HALF_W-1:0] oDATA_HI;
    logic              oWR;
    logic [WCNT_W-1:0] oWORD_CNT;
    logic              oFRAME_DONE;
    logic              oOVERRUN;
    logic              oBUSY;

    modport master (
        output iPIX, iDVAL, iFVAL, iENABLE, iFULL,
        input  oDATA_LO, oDATA_HI, oWR, oWORD_CNT,
        input  oFRAME_DONE, oOVERRUN, oBUSY
    );

    modport slave (
        input  iPIX, iDVAL, iFVAL, iENABLE, iFULL,
        output oDATA_LO, oDATA_HI, oWR, oWORD_CNT,
        output oFRAME_DONE, oOVERRUN, oBUSY
    );

endinterface

// File: rtl/pix_word_hold.sv
// One-word holding register between the packer and the SDRAM write FIFOs.
// Ports: ld/ld_word offer a word, ld_flush marks a no-drop offer, full is
// back-pressure; wr strobe, rdy (can take a word), drop, pend, data halves.
module pix_word_hold
    import pix_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic              ld_flush,
    input  logic [WORD_W-1:0] ld_word,
    input  logic              full,
    output logic              wr,
    output logic              rdy,
    output logic              drop,
    output logic              pend,
    output logic [HALF_W-1:0] data_lo,
    output logic [HALF_W-1:0] data_hi
);

    logic              pend_q, pend_d;
    logic [WORD_W-1:0] word_q, word_d;

    assign wr   = pend_q & ~full;
    // Slot is free now or is being emptied in this very cycle.
    assign rdy  = ~pend_q | wr;
    // A flush offer simply waits; only a live completed word can be lost.
    assign drop = ld & ~rdy & ~ld_flush;

    always_comb begin
        pend_d = pend_q;
        word_d = word_q;
        if (wr) pend_d = 1'b0;
        if (ld && rdy) begin
            pend_d = 1'b1;
            word_d = ld_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            word_q <= '0;
        end else begin
            pend_q <= pend_d;
            word_q <= word_d;
        end
    end

    assign pend    = pend_q;
    assign data_lo = word_q[HALF_W-1:0];
    assign data_hi = word_q[WORD_W-1:HALF_W];

endmodule

// File: rtl/pixel_word_packer.sv
// Frames the thresholded 1-bit pixel stream on FVAL and packs it into
// 32-bit words (pixel 0 in bit 0). Ports: iCLK, iRST_N, bus (slave side).
module pixel_word_packer
    import pix_pack_pkg::*;
#(
    parameter int MAX_PIX = FRAME_PIXELS
)
(
    input  logic                iCLK,
    input  logic                iRST_N,
    pixel_word_packer_if.slave  bus
);

    localparam logic [PCNT_W-1:0] PIX_LIM  = PCNT_W'(MAX_PIX);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

    state_t            state_q, state_d;
    logic              fval_q;
    logic [BCNT_W-1:0] bit_q, bit_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [PCNT_W-1:0] pix_q, pix_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              cap_hit;

    logic              ld, ld_flush;
    logic [WORD_W-1:0] ld_word;
    logic              wr, hold_rdy, hold_drop, hold_pend;

    pix_word_hold u_hold (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .ld       (ld),
        .ld_flush (ld_flush),
        .ld_word  (ld_word),
        .full     (bus.iFULL),
        .wr       (wr),
        .rdy      (hold_rdy),
        .drop     (hold_drop),
        .pend     (hold_pend),
        .data_lo  (bus.oDATA_LO),
        .data_hi  (bus.oDATA_HI)
    );

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        pack_d   = pack_q;
        pix_d    = pix_q;
        wcnt_d   = wcnt_q;
        done_d   = 1'b0;
        cap_hit  = 1'b0;
        ld       = 1'b0;
        ld_flush = 1'b0;
        ld_word  = pack_q;

        if (wr && wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.iFVAL && !fval_q && bus.iENABLE) begin
                    state_d = ACTIVE;
                    bit_d   = '0;
                    pack_d  = '0;
                    pix_d   = '0;
                    wcnt_d  = '0;
                end
            end
            ACTIVE: begin
                // FVAL low gates the pixel of this cycle as well.
                if (!bus.iFVAL) begin
                    state_d = (bit_q != '0) ? FLUSH : DONE;
                end else if (bus.iDVAL) begin
                    if (pix_q < PIX_LIM) begin
                        pix_d = pix_q + 1'b1;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            ld                  = 1'b1;
                            ld_word[WORD_W-1]   = bus.iPIX;
                            pack_d              = '0;
                        end else begin
                            pack_d[bit_q] = bus.iPIX;
                        end
                    end else begin
                        cap_hit = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Unwritten bits of pack_q are already zero.
                ld       = 1'b1;
                ld_flush = 1'b1;
                if (hold_rdy) state_d = DONE;
            end
            DONE: begin
                if (!hold_pend || wr) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovr_d = ovr_q | cap_hit | hold_drop;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            fval_q  <= 1'b0;
            bit_q   <= '0;
            pack_q  <= '0;
            pix_q   <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fval_q  <= bus.iFVAL;
            bit_q   <= bit_d;
            pack_q  <= pack_d;
            pix_q   <= pix_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.oWR         = wr;
    assign bus.oWORD_CNT   = wcnt_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oOVERRUN    = ovr_q;
    assign bus.oBUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer with a 320-pixel (10-word) frame cap.
// A negedge monitor collects written words and frame-done word counts.
module tb_pixel_word_packer;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;

    pixel_word_packer_if bus();

    pixel_word_packer #(.MAX_PIX(320)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;
    int pix_idx = 0;
    int done_seen = 0;
    int done_cnt = 0;
    logic [31:0] words[$];

    always @(negedge iCLK) begin
        if (bus.oWR) words.push_back({bus.oDATA_HI, bus.oDATA_LO});
        if (bus.oFRAME_DONE) begin
            done_seen++;
            done_cnt = int'(bus.oWORD_CNT);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start_frame();
        words.delete();
        pix_idx = 0;
        bus.iDVAL = 1'b0;
        bus.iFVAL = 1'b1;
        tick();
    endtask

    task automatic send(int n, logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            bus.iDVAL = 1'b1;
            bus.iPIX  = pat[pix_idx % 32];
            pix_idx++;
            tick();
        end
        bus.iDVAL = 1'b0;
    endtask

    task automatic end_frame_wait(string tag);
        int d0;
        int n;
        d0 = done_seen;
        n = 0;
        bus.iDVAL = 1'b0;
        bus.iFVAL = 1'b0;
        while (done_seen == d0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_seen != d0), 32'd1);
    endtask

    task automatic bad_words(logic [31:0] exp, output int bad);
        bad = 0;
        foreach (words[i]) if (words[i] !== exp) bad++;
    endtask

    int bad;
    logic [31:0] p;

    initial begin
        bus.iPIX = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iFVAL = 1'b0;
        bus.iENABLE = 1'b1;
        bus.iFULL = 1'b0;
        #2;
        chk("rst_wr", 32'(bus.oWR), 0);
        chk("rst_lo", 32'(bus.oDATA_LO), 0);
        chk("rst_hi", 32'(bus.oDATA_HI), 0);
        chk("rst_cnt", 32'(bus.oWORD_CNT), 0);
        chk("rst_done", 32'(bus.oFRAME_DONE), 0);
        chk("rst_ovr", 32'(bus.oOVERRUN), 0);
        chk("rst_busy", 32'(bus.oBUSY), 0);
        #20;
        iRST_N = 1'b1;
        repeat (2) tick();

        // Full capped frame, alternating 1,0 -> 0x55555555 words.
        start_frame();
        chk("a_busy", 32'(bus.oBUSY), 1);
        send(320, 32'h5555_5555);
        end_frame_wait("a_done_timeout");
        chk("a_nwords", words.size(), 10);
        bad_words(32'h5555_5555, bad);
        chk("a_badwords", bad, 0);
        chk("a_done_cnt", done_cnt, 10);
        chk("a_ovr", 32'(bus.oOVERRUN), 0);
        chk("a_idle", 32'(bus.oBUSY), 0);

        // 40 ones: full word then flushed 8-bit partial.
        start_frame();
        send(32, 32'hFFFF_FFFF);
        chk("b_lat_wr", 32'(bus.oWR), 1);
        chk("b_lat_data", {bus.oDATA_HI, bus.oDATA_LO}, 32'hFFFF_FFFF);
        send(8, 32'hFFFF_FFFF);
        end_frame_wait("b_done_timeout");
        chk("b_nwords", words.size(), 2);
        chk("b_w0", words[0], 32'hFFFF_FFFF);
        chk("b_w1", words[1], 32'h0000_00FF);
        chk("b_done_cnt", done_cnt, 2);

        // FULL for 20 cycles: word waits, nothing lost.
        p = 32'h0F0F_3C3C;
        start_frame();
        send(32, p);
        bus.iFULL = 1'b1;
        send(20, p);
        chk("c_wr_blocked", 32'(bus.oWR), 0);
        chk("c_held", {bus.oDATA_HI, bus.oDATA_LO}, p);
        bus.iFULL = 1'b0;
        #1;
        chk("c_wr_release", 32'(bus.oWR), 1);
        send(12, p);
        end_frame_wait("c_done_timeout");
        chk("c_nwords", words.size(), 2);
        bad_words(p, bad);
        chk("c_badwords", bad, 0);
        chk("c_ovr", 32'(bus.oOVERRUN), 0);

        // Disabled at FVAL rise: frame ignored.
        bus.iENABLE = 1'b0;
        start_frame();
        chk("d_busy_off", 32'(bus.oBUSY), 0);
        send(32, 32'h1234_5678);
        bus.iFVAL = 1'b0;
        repeat (5) tick();
        chk("d_nwords", words.size(), 0);
        chk("d_busy_end", 32'(bus.oBUSY), 0);

        // Enable dropped mid-frame: frame still completes.
        bus.iENABLE = 1'b1;
        p = 32'h1234_5678;
        start_frame();
        send(10, p);
        bus.iENABLE = 1'b0;
        send(22, p);
        end_frame_wait("d_done_timeout");
        chk("d_mid_nwords", words.size(), 1);
        chk("d_mid_w0", words[0], p);
        bus.iENABLE = 1'b1;

        // Reset after 20 pixels, then a clean frame.
        start_frame();
        send(20, 32'hFFFF_FFFF);
        iRST_N = 1'b0;
        bus.iFVAL = 1'b0;
        #1;
        chk("e_busy", 32'(bus.oBUSY), 0);
        chk("e_wr", 32'(bus.oWR), 0);
        chk("e_data", {bus.oDATA_HI, bus.oDATA_LO}, 0);
        chk("e_cnt", 32'(bus.oWORD_CNT), 0);
        #3;
        iRST_N = 1'b1;
        tick();
        p = 32'hA5C3_1E77;
        start_frame();
        send(32, p);
        end_frame_wait("e_done_timeout");
        chk("e_nwords", words.size(), 1);
        chk("e_w0", words[0], p);

        // FULL for 40 cycles at full rate: second word dropped.
        p = 32'hC001_D00D;
        start_frame();
        send(32, p);
        bus.iFULL = 1'b1;
        send(32, p);
        chk("f_ovr_on_drop", 32'(bus.oOVERRUN), 1);
        repeat (8) tick();
        bus.iFULL = 1'b0;
        end_frame_wait("f_done_timeout");
        chk("f_nwords", words.size(), 1);
        chk("f_w0", words[0], p);
        chk("f_done_cnt", done_cnt, 1);

        // Overrun is sticky until reset; then pixel cap test.
        iRST_N = 1'b0;
        #3;
        chk("g_ovr_clr", 32'(bus.oOVERRUN), 0);
        iRST_N = 1'b1;
        tick();
        start_frame();
        send(330, 32'hFFFF_FFFF);
        end_frame_wait("g_done_timeout");
        chk("g_nwords", words.size(), 10);
        bad_words(32'hFFFF_FFFF, bad);
        chk("g_badwords", bad, 0);
        chk("g_done_cnt", done_cnt, 10);
        chk("g_ovr_cap", 32'(bus.oOVERRUN), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
